// File: rtl/hc595_pkg.sv
// Shared encodings and sizing helpers for the 74HC595 chain controller.
package hc595_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SHIFT_LO = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_CLEAR    = 3'd3;
  localparam logic [2:0] S_LATCH_HI = 3'd4;
  localparam logic [2:0] S_LATCH_LO = 3'd5;

  function automatic int data_w(input int n_dev);
    return 8 * n_dev;
  endfunction

  function automatic int cnt_w(input int clk_div);
    return (clk_div <= 2) ? 1 : $clog2(clk_div);
  endfunction

endpackage

// File: rtl/hc595_chain_ctrl_phase_timer.sv
// Loadable down-counter that times every controller phase.
module hc595_phase_timer
  import hc595_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hc595_chain_ctrl.sv
// Serializes words into a 74HC595 chain and handles latch, clear and OE.
// Optional SQH readback of the previous chain contents: HC595_READBACK_EN.
module hc595_chain_ctrl
  import hc595_pkg::*;
#(
  parameter int N_DEV     = 1,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [8*N_DEV-1:0]   DIN,
  input  logic                 DIN_VALID,
  output logic                 DIN_READY,
  input  logic                 CLR_REQ,
  input  logic                 OE_REQ,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 A,
  output logic                 SHIFTCLOCK,
  output logic                 LATCHCLOCK,
  output logic                 OUTPUTENABLE,
  output logic                 SRCLR_N,
  input  logic                 SQH,
  output logic [8*N_DEV-1:0]   RDATA,
  output logic                 RDATA_VALID
);

  localparam int DW = data_w(N_DEV);
  localparam int CW = cnt_w(CLK_DIV);
  localparam int BW = $clog2(DW + 1);

  logic [2:0]    state, state_nxt;
  logic          zero;
  logic          xfer;
  logic          armed;
  logic [DW-1:0] sbuf, sbuf_nxt;
  logic [BW-1:0] bit_cnt;
  logic          a_d, sclk_d, lclk_d;
  logic          srclr_d, busy_d, done_d;

  assign DIN_READY = (state == S_IDLE) && !CLR_REQ;
  assign xfer      = DIN_VALID && DIN_READY;

  hc595_phase_timer #(.W(CW)) u_timer (
    .clk      (CLOCK),
    .rst      (RESET),
    .load     (state_nxt != state),
    .load_val (CW'(CLK_DIV - 1)),
    .zero     (zero)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (CLR_REQ)        state_nxt = S_CLEAR;
        else if (DIN_VALID) state_nxt = S_SHIFT_LO;
      end
      S_SHIFT_LO: if (zero) state_nxt = S_SHIFT_HI;
      S_SHIFT_HI: begin
        if (zero)
          state_nxt = (bit_cnt == BW'(DW)) ? S_LATCH_HI
                                           : S_SHIFT_LO;
      end
      S_CLEAR:    if (zero) state_nxt = S_LATCH_HI;
      S_LATCH_HI: if (zero) state_nxt = S_LATCH_LO;
      S_LATCH_LO: if (zero) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sbuf_nxt = sbuf;
    if (xfer)
      sbuf_nxt = DIN;
    else if (state == S_SHIFT_HI && zero)
      sbuf_nxt = MSB_FIRST ? (sbuf << 1) : (sbuf >> 1);
  end

  // Pins are decoded from the next state so the registers line up with it.
  always_comb begin
    a_d = 1'b0;
    if (state_nxt == S_SHIFT_LO || state_nxt == S_SHIFT_HI)
      a_d = MSB_FIRST ? sbuf_nxt[DW-1] : sbuf_nxt[0];
    sclk_d  = (state_nxt == S_SHIFT_HI);
    lclk_d  = (state_nxt == S_LATCH_HI);
    srclr_d = (state_nxt != S_CLEAR);
    busy_d  = (state_nxt != S_IDLE);
    done_d  = (state == S_LATCH_LO) && (state_nxt == S_IDLE);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sbuf         <= '0;
      bit_cnt      <= '0;
      armed        <= 1'b0;
      A            <= 1'b0;
      SHIFTCLOCK   <= 1'b0;
      LATCHCLOCK   <= 1'b0;
      OUTPUTENABLE <= 1'b1;
      SRCLR_N      <= 1'b1;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      sbuf <= sbuf_nxt;
      if (xfer)
        bit_cnt <= '0;
      else if (state == S_SHIFT_LO && zero)
        bit_cnt <= bit_cnt + BW'(1);
      if (done_d) armed <= 1'b1;
      A            <= a_d;
      SHIFTCLOCK   <= sclk_d;
      LATCHCLOCK   <= lclk_d;
      OUTPUTENABLE <= !(OE_REQ && armed);
      SRCLR_N      <= srclr_d;
      BUSY         <= busy_d;
      DONE         <= done_d;
    end
  end

`ifdef HC595_READBACK_EN
  logic [DW-1:0] cap;
  logic          frame;

  // SQH is sampled just before each shift edge moves the chain.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cap         <= '0;
      frame       <= 1'b0;
      RDATA       <= '0;
      RDATA_VALID <= 1'b0;
    end else begin
      if (xfer)
        frame <= 1'b1;
      else if (state == S_IDLE && CLR_REQ)
        frame <= 1'b0;
      if (state == S_SHIFT_LO && zero)
        cap <= MSB_FIRST ? {cap[DW-2:0], SQH}
                         : {SQH, cap[DW-1:1]};
      RDATA_VALID <= done_d && frame;
      if (done_d && frame) RDATA <= cap;
    end
  end
`else
  logic unused_sqh;
  assign unused_sqh  = SQH;
  assign RDATA       = '0;
  assign RDATA_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// Directed bench for hc595_chain_ctrl with behavioural 74HC595 chain models.
module tb_hc595_chain_ctrl;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // single-device instance
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        clr_req = 1'b0;
  logic        oe_req = 1'b1;
  logic        din_ready, busy, done, a, sclk, lclk, oe_n, srclr_n, sqh;
  logic [7:0]  rdata;
  logic        rdata_valid;

  // two-device instance
  logic [15:0] din2 = '0;
  logic        din_valid2 = 1'b0;
  logic        clr_req2 = 1'b0;
  logic        din_ready2, busy2, done2, a2, sclk2, lclk2, oe_n2, srclr2, sqh2;
  logic [15:0] rdata2;
  logic        rdata_valid2;

  hc595_chain_ctrl #(.N_DEV(1), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .DIN(din), .DIN_VALID(din_valid),
    .DIN_READY(din_ready), .CLR_REQ(clr_req), .OE_REQ(oe_req),
    .BUSY(busy), .DONE(done), .A(a), .SHIFTCLOCK(sclk),
    .LATCHCLOCK(lclk), .OUTPUTENABLE(oe_n), .SRCLR_N(srclr_n),
    .SQH(sqh), .RDATA(rdata), .RDATA_VALID(rdata_valid)
  );

  hc595_chain_ctrl #(.N_DEV(2), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut2 (
    .CLOCK(CLOCK), .RESET(RESET), .DIN(din2), .DIN_VALID(din_valid2),
    .DIN_READY(din_ready2), .CLR_REQ(clr_req2), .OE_REQ(oe_req),
    .BUSY(busy2), .DONE(done2), .A(a2), .SHIFTCLOCK(sclk2),
    .LATCHCLOCK(lclk2), .OUTPUTENABLE(oe_n2), .SRCLR_N(srclr2),
    .SQH(sqh2), .RDATA(rdata2), .RDATA_VALID(rdata_valid2)
  );

  // 595 chain models: bit 0 is Qa of device 0
  logic [7:0]  sr1 = '0, st1 = '0;
  logic [31:0] ahist = '0;
  int          sc1 = 0, lc1 = 0;
  logic [15:0] sr2 = '0, st2 = '0;
  int          sc2 = 0;

  always @(posedge sclk or negedge srclr_n)
    if (!srclr_n) sr1 <= '0;
    else          sr1 <= {sr1[6:0], a};
  always @(posedge sclk) begin
    sc1   <= sc1 + 1;
    ahist <= {ahist[30:0], a};
  end
  always @(posedge lclk) begin
    st1 <= sr1;
    lc1 <= lc1 + 1;
  end
  assign sqh = sr1[7];

  always @(posedge sclk2 or negedge srclr2)
    if (!srclr2) sr2 <= '0;
    else         sr2 <= {sr2[14:0], a2};
  always @(posedge sclk2) sc2 <= sc2 + 1;
  always @(posedge lclk2) st2 <= sr2;
  assign sqh2 = sr2[15];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done1(output int cyc, output int lows,
                            output logic b0);
    cyc  = 0;
    lows = 0;
    @(negedge CLOCK);
    b0 = busy;
    while (!done && cyc < 200) begin
      if (!srclr_n) lows++;
      @(negedge CLOCK);
      cyc++;
    end
  endtask

  task automatic wait_done2(output int cyc);
    cyc = 0;
    @(negedge CLOCK);
    while (!done2 && cyc < 300) begin
      @(negedge CLOCK);
      cyc++;
    end
  endtask

  initial begin
    int   cyc, lows, n, sc_b, lc_b;
    logic b0;

    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("rst_a", a, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_lclk", lclk, 0);
    chk("rst_oe", oe_n, 1);
    chk("rst_srclr", srclr_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_ready", din_ready, 1);
    chk("rst_busy2", busy2, 0);
    RESET = 1'b0;

    // frame 8'hA5
    din = 8'hA5; din_valid = 1'b1;
    sc_b = sc1; lc_b = lc1;
    @(posedge CLOCK); #1 din_valid = 1'b0;
    wait_done1(cyc, lows, b0);
    chk("frame_busy", b0, 1);
    chk("frame_len", cyc, 36);
    chk("frame_sclk", sc1 - sc_b, 8);
    chk("frame_a_seq", ahist[7:0], 8'hA5);
    chk("frame_latch", lc1 - lc_b, 1);
    chk("frame_q", st1, 8'hA5);
    chk("frame_ready_done", din_ready, 1);
    chk("oe_at_done", oe_n, 1);
    @(negedge CLOCK);
    chk("oe_after_done", oe_n, 0);
    chk("busy_idle", busy, 0);
    chk("done_pulse", done, 0);

    // OE_REQ gating latency
    oe_req = 1'b0;
    #1 chk("oe_drop_hold", oe_n, 0);
    @(negedge CLOCK);
    chk("oe_drop", oe_n, 1);
    oe_req = 1'b1;
    @(negedge CLOCK);
    chk("oe_restore", oe_n, 0);

    // clear wins over a simultaneous word
    clr_req = 1'b1; din = 8'h5A; din_valid = 1'b1;
    sc_b = sc1; lc_b = lc1;
    #1 chk("clr_ready", din_ready, 0);
    @(posedge CLOCK); #1 clr_req = 1'b0;
    wait_done1(cyc, lows, b0);
    chk("clr_len", cyc, 6);
    chk("clr_lows", lows, 2);
    chk("clr_busy", b0, 1);
    chk("clr_sclk", sc1 - sc_b, 0);
    chk("clr_latch", lc1 - lc_b, 1);
    chk("clr_q", st1, 8'h00);
    chk("clr_rvalid", rdata_valid, 0);
    chk("clr_ready_done", din_ready, 1);
    @(posedge CLOCK); #1 din_valid = 1'b0;
    wait_done1(cyc, lows, b0);
    chk("post_clr_len", cyc, 36);
    chk("post_clr_q", st1, 8'h5A);
`ifdef HC595_READBACK_EN
    chk("post_clr_rdata", rdata, 8'h00);
    chk("post_clr_rvalid", rdata_valid, 1);
`else
    chk("post_clr_rdata", rdata, 8'h00);
    chk("post_clr_rvalid", rdata_valid, 0);
`endif

    // reset after the third shift edge
    din = 8'hFF; din_valid = 1'b1;
    sc_b = sc1; lc_b = lc1;
    @(posedge CLOCK); #1 din_valid = 1'b0;
    n = 0;
    while (sc1 - sc_b < 3 && n < 100) begin
      @(negedge CLOCK);
      n++;
    end
    chk("mid_reached", sc1 - sc_b, 3);
    RESET = 1'b1;
    @(negedge CLOCK);
    chk("mid_a", a, 0);
    chk("mid_sclk", sclk, 0);
    chk("mid_lclk", lclk, 0);
    chk("mid_srclr", srclr_n, 1);
    chk("mid_oe", oe_n, 1);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    RESET = 1'b0;
    repeat (60) @(negedge CLOCK);
    chk("mid_no_latch", lc1 - lc_b, 0);
    chk("mid_q", st1, 8'h5A);
    chk("mid_oe_unarmed", oe_n, 1);
    chk("mid_sclk_stop", sc1 - sc_b, 3);

`ifdef HC595_READBACK_EN
    // chain holds 5A shifted by three ones: D7
    din = 8'h3C; din_valid = 1'b1;
    @(posedge CLOCK); #1 din_valid = 1'b0;
    wait_done1(cyc, lows, b0);
    chk("rb1_rdata", rdata, 8'hD7);
    chk("rb1_rvalid", rdata_valid, 1);
    din = 8'hF0; din_valid = 1'b1;
    @(posedge CLOCK); #1 din_valid = 1'b0;
    wait_done1(cyc, lows, b0);
    chk("rb2_rdata", rdata, 8'h3C);
    chk("rb2_rvalid", rdata_valid, 1);
    chk("rb2_q", st1, 8'hF0);
    @(negedge CLOCK);
    chk("rb_pulse", rdata_valid, 0);
`endif

    // two-device chain
    din2 = 16'h1234; din_valid2 = 1'b1;
    sc_b = sc2;
    @(posedge CLOCK); #1 din_valid2 = 1'b0;
    wait_done2(cyc);
    chk("chain_len", cyc, 68);
    chk("chain_sclk", sc2 - sc_b, 16);
    chk("chain_dev0", st2[7:0], 8'h34);
    chk("chain_dev1", st2[15:8], 8'h12);
    chk("chain_ready", din_ready2, 1);
`ifdef HC595_READBACK_EN
    chk("chain_rdata", rdata2, 16'h0000);
    chk("chain_rvalid", rdata_valid2, 1);
`else
    chk("chain_rdata", rdata2, 16'h0000);
    chk("chain_rvalid", rdata_valid2, 0);
`endif
    @(negedge CLOCK);
    chk("chain_oe", oe_n2, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hc595_chain_ctrl.md
Name: hc595_chain_ctrl

Overview:
- Sequencer driving one or more daisy-chained 74HC595 shift/latch registers from a single system clock.
- Accepts a parallel word over a valid/ready handshake, serializes it onto the chip's serial input and generates SHIFTCLOCK pulses.
- Pulses LATCHCLOCK to transfer the word to the outputs, then manages output enable and the chip clear line.
- Sits between the register-write logic and the board-level 595 pins.

Parameters:
- N_DEV, 1, number of chained 74HC595 devices; word width is 8*N_DEV.
- CLK_DIV, 2, system cycles per half period of SHIFTCLOCK and LATCHCLOCK; minimum 1.
- MSB_FIRST, 1, 1: DIN[8*N_DEV-1] shifted first; 0: DIN[0] shifted first.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- DIN  in  8*N_DEV  word to display; DIN[7:0] maps to the device nearest the controller.
- DIN_VALID  in  1  DIN valid.
- DIN_READY  out  1  controller can accept DIN.
- CLR_REQ  in  1  one-cycle request to clear all outputs to 0.
- OE_REQ  in  1  level; 1 = outputs should drive.
- BUSY  out  1  frame or clear in progress.
- DONE  out  1  one-cycle pulse when a frame or clear has been latched.
- A  out  1  serial data to the first 595.
- SHIFTCLOCK  out  1  595 shift clock.
- LATCHCLOCK  out  1  595 storage clock.
- OUTPUTENABLE  out  1  595 output enable, active low.
- SRCLR_N  out  1  595 shift-register clear, active low.
- SQH  in  1  serial output of the last device in the chain.
- RDATA  out  8*N_DEV  previous chain contents (readback; see Optional Feature).
- RDATA_VALID  out  1  RDATA updated (readback; see Optional Feature).

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; A=0, SHIFTCLOCK=0, LATCHCLOCK=0, OUTPUTENABLE=1, SRCLR_N=1, BUSY=0, DONE=0, RDATA=0, RDATA_VALID=0; the armed flag is cleared.
- RESET asserted mid-frame aborts the frame immediately. Pins return to reset values on the next edge. No LATCHCLOCK pulse is emitted.
- States: IDLE, SHIFT_LO, SHIFT_HI, CLEAR, LATCH_HI, LATCH_LO.
- A down-counter reloads to CLK_DIV-1 on every state entry. A state is left when the counter reaches 0, so each phase lasts exactly CLK_DIV cycles.
- DIN_READY = (state==IDLE) && !CLR_REQ.
- Handshake: a transfer occurs when DIN_VALID && DIN_READY. DIN is captured into a shift buffer and the controller enters SHIFT_LO on the next cycle. BUSY=1 from that cycle until the return to IDLE.
- SHIFT_LO: A holds the current bit; SHIFTCLOCK=0.
- SHIFT_HI: SHIFTCLOCK=1; A is stable. On exit the buffer advances.
  - If the bit counter (width $clog2(8*N_DEV+1)) has reached 8*N_DEV, go to LATCH_HI; otherwise go to SHIFT_LO.
- CLR_REQ in IDLE has priority over DIN_VALID. The controller enters CLEAR (SRCLR_N=0 for CLK_DIV cycles), then goes to LATCH_HI. CLR_REQ outside IDLE is ignored.
- LATCH_HI: LATCHCLOCK=1. LATCH_LO: LATCHCLOCK=0, which gives hold time. The controller then returns to IDLE, where DONE=1 for that first IDLE cycle.
- Frame length from the first SHIFT_LO cycle to the DONE cycle: (16*N_DEV+2)*CLK_DIV cycles.
- Clear length from CLEAR entry to DONE: 3*CLK_DIV cycles.
- The armed flag is set by the first completed latch.
- OUTPUTENABLE = !(OE_REQ && armed), registered with one cycle of latency, so the chip's garbage power-up contents are never driven.
- Bit mapping with MSB_FIRST=1: after a frame, DIN[0] sits on Qa of device 0 and DIN[7] sits on Qh of device 0.
- Back-to-back frames: DIN_READY is high in the DONE cycle, so a new transfer may occur there.

Optional Feature:
- Macro: HC595_READBACK_EN.
- With the macro defined:
  - SQH is sampled on the last cycle of every SHIFT_LO phase and shifted into a capture register in the same order as the shift direction.
  - At DONE of a data frame, RDATA holds the chain contents from before that frame, and RDATA_VALID pulses with DONE.
  - A clear does not update RDATA.
- Without the macro: SQH is ignored, and RDATA and RDATA_VALID are tied to 0.

Decomposition:
- Package hc595_pkg holds:
  - the state encodings (localparam, 3 bits);
  - the DATA_W = 8*N_DEV helper;
  - CNT_W = $clog2(CLK_DIV) with minimum 1.
- One sub-module, hc595_phase_timer: the loadable down-counter with a zero flag used by every phase.

Test Plan:
- Frame: N_DEV=1, CLK_DIV=2; send DIN=8'hA5 -> 8 SHIFTCLOCK rising edges, A sequence 1,0,1,0,0,1,0,1, one LATCHCLOCK pulse. DONE arrives 36 cycles after the first SHIFT_LO cycle; the 595 model shows Qh..Qa = 10100101.
- Enable gating: hold OE_REQ=1 from reset -> OUTPUTENABLE stays 1 until the cycle after the first DONE, then goes 0. Drop OE_REQ -> OUTPUTENABLE=1 one cycle later.
- Clear priority: assert CLR_REQ and DIN_VALID together in IDLE -> DIN_READY=0, SRCLR_N low for 2 cycles, latch pulse, model outputs 8'h00, DONE at cycle 6. The DIN transfer is accepted afterwards.
- Chain: N_DEV=2, DIN=16'h1234 -> 16 shift pulses, device 0 shows 8'h34 and device 1 shows 8'h12, DONE after 68 cycles.
- Reset mid-frame: assert RESET after the 3rd SHIFTCLOCK edge -> next cycle all pins at reset values and no LATCHCLOCK pulse; model outputs unchanged.
- Readback (HC595_READBACK_EN): send 8'h3C, then 8'hF0 -> second DONE has RDATA=8'h3C with RDATA_VALID=1.
